// File: rtl/draw_map_pkg.sv
// Shared types and constants for the tile-map renderer.
package draw_map_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_FETCH     = 3'd2,
    S_WAIT_DATA = 3'd3,
    S_ISSUE     = 3'd4,
    S_WAIT_SQ   = 3'd5,
    S_NEXT      = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  localparam logic [1:0] TILE_FLOOR = 2'd0;
  localparam logic [1:0] TILE_WALL  = 2'd1;
  localparam logic [1:0] TILE_DOOR  = 2'd2;
  localparam logic [1:0] TILE_RSVD  = 2'd3;

  localparam int unsigned SQUARE_SIZE = 4;

  // Reserved code renders as wall so unexpected data stays impassable-looking.
  function automatic logic [17:0] palette(input logic [1:0]  code,
                                          input logic [17:0] floor_c,
                                          input logic [17:0] wall_c,
                                          input logic [17:0] door_c);
    case (code)
      TILE_FLOOR: return floor_c;
      TILE_DOOR:  return door_c;
      default:    return wall_c;
    endcase
  endfunction

endpackage

// File: rtl/draw_map_cursor.sv
// Row-major tile cursor: clears on reset_cursor, steps on increment, flags the last tile.
module draw_map_cursor #(
  parameter int unsigned MAP_W = 16,
  parameter int unsigned MAP_H = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       reset_cursor,
  input  logic       increment,
  output logic [3:0] col,
  output logic [3:0] row,
  output logic       at_last
);

  localparam logic [3:0] COL_LAST = 4'(MAP_W - 1);
  localparam logic [3:0] ROW_LAST = 4'(MAP_H - 1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (reset_cursor) begin
      col <= '0;
      row <= '0;
    end else if (increment) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 4'd1;
      end else begin
        col <= col + 4'd1;
      end
    end
  end

  assign at_last = (col == COL_LAST) && (row == ROW_LAST);

endmodule

// File: rtl/draw_map.sv
// Walks the tile map and hands one coloured 4x4 square per tile to the square drawer.
module draw_map
  import draw_map_pkg::*;
#(
  parameter int unsigned MAP_W         = 16,
  parameter int unsigned MAP_H         = 16,
  parameter logic [7:0]  MAP_X0        = 8'd0,
  parameter logic [6:0]  MAP_Y0        = 7'd0,
  parameter logic [17:0] FLOOR_COLOUR  = 18'h00000,
  parameter logic [17:0] WALL_COLOUR   = 18'h3FFFF,
  parameter logic [17:0] DOOR_COLOUR   = 18'h3F000,
  parameter logic [17:0] PLAYER_COLOUR = 18'h00FC0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  input  logic [3:0]  player_x,
  input  logic [3:0]  player_y,
  output logic [7:0]  map_addr,
  input  logic [1:0]  map_data,
  output logic        sq_start,
  output logic [7:0]  sq_x,
  output logic [6:0]  sq_y,
  output logic [17:0] sq_colour,
  input  logic        sq_done
);

  state_t     state, state_nxt;
  logic [3:0] col, row;
  logic       at_last;
  logic       reset_cursor, cursor_inc;
  logic [3:0] player_xl, player_yl;
  logic       is_player;

  draw_map_cursor #(
    .MAP_W(MAP_W),
    .MAP_H(MAP_H)
  ) u_cursor (
    .clock       (clock),
    .reset       (reset),
    .reset_cursor(reset_cursor),
    .increment   (cursor_inc),
    .col         (col),
    .row         (row),
    .at_last     (at_last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start) state_nxt = S_LOAD;
      S_LOAD:      state_nxt = S_FETCH;
      S_FETCH:     state_nxt = S_WAIT_DATA;
      S_WAIT_DATA: state_nxt = S_ISSUE;
      S_ISSUE:     state_nxt = S_WAIT_SQ;
      S_WAIT_SQ:   if (sq_done) state_nxt = S_NEXT;
      S_NEXT:      state_nxt = at_last ? S_DONE : S_FETCH;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // sq_start is decoded from ISSUE; the square registers load on the same edge,
  // so the drawer sees them valid the cycle after the request.
  always_comb begin
    sq_start     = (state == S_ISSUE);
    done         = (state == S_DONE);
    reset_cursor = (state == S_LOAD);
    cursor_inc   = (state == S_NEXT);
  end

  assign map_addr  = 8'(row) * 8'(MAP_W) + 8'(col);
  assign is_player = (col == player_xl) && (row == player_yl);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      player_xl <= '0;
      player_yl <= '0;
      sq_x      <= '0;
      sq_y      <= '0;
      sq_colour <= '0;
    end else begin
      if (state == S_LOAD) begin
        player_xl <= player_x;
        player_yl <= player_y;
      end
      if (state == S_ISSUE) begin
        sq_x      <= MAP_X0 + 8'(col) * 8'(SQUARE_SIZE);
        sq_y      <= MAP_Y0 + 7'(row) * 7'(SQUARE_SIZE);
        sq_colour <= is_player ? PLAYER_COLOUR
                               : palette(map_data, FLOOR_COLOUR, WALL_COLOUR, DOOR_COLOUR);
      end
    end
  end

endmodule

// File: tb/tb_draw_map.sv
// Directed bench for draw_map: default 16x16 map plus an offset 8x4 instance.
module tb_draw_map;

  localparam logic [17:0] FLOOR  = 18'h00000;
  localparam logic [17:0] WALL   = 18'h3FFFF;
  localparam logic [17:0] DOOR   = 18'h3F000;
  localparam logic [17:0] PLAYER = 18'h00FC0;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  player_x = 4'd5, player_y = 4'd7;
  logic        done, sq_start, sq_done = 1'b0;
  logic [7:0]  map_addr, sq_x;
  logic [6:0]  sq_y;
  logic [17:0] sq_colour;
  logic [1:0]  map_data = 2'd0;

  logic        start2 = 1'b0, done2, sq_start2, sq_done2 = 1'b0;
  logic [7:0]  map_addr2, sq_x2;
  logic [6:0]  sq_y2;
  logic [17:0] sq_colour2;
  logic [1:0]  map_data2 = 2'd0;

  int unsigned n_vec = 0, n_miss = 0;

  always #5 clock = ~clock;

  draw_map dut (
    .clock(clock), .reset(reset), .start(start), .done(done),
    .player_x(player_x), .player_y(player_y),
    .map_addr(map_addr), .map_data(map_data),
    .sq_start(sq_start), .sq_x(sq_x), .sq_y(sq_y), .sq_colour(sq_colour),
    .sq_done(sq_done)
  );

  draw_map #(.MAP_W(8), .MAP_H(4), .MAP_X0(8'd32), .MAP_Y0(7'd20)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .done(done2),
    .player_x(4'd0), .player_y(4'd0),
    .map_addr(map_addr2), .map_data(map_data2),
    .sq_start(sq_start2), .sq_x(sq_x2), .sq_y(sq_y2), .sq_colour(sq_colour2),
    .sq_done(sq_done2)
  );

  // Map RAM models: code = (row + col) mod 4, one cycle read latency.
  always @(posedge clock) begin
    map_data  <= 2'(map_addr[7:4] + map_addr[3:0]);
    map_data2 <= 2'({1'b0, map_addr2[4:3]} + map_addr2[2:0]);
  end

  int unsigned epoch = 0;
  always @(negedge reset) epoch++;

  // Square drawer stub for dut: records each square, checks hold/overlap, answers after sq_delay.
  int unsigned sq_delay = 3, frame_base = 0;
  int unsigned n_sq = 0, n_done = 0, hold_viol = 0, overlap_viol = 0;
  logic [7:0]  rec_x [256];
  logic [6:0]  rec_y [256];
  logic [17:0] rec_colour [256];
  logic [7:0]  rec_addr [256];

  always begin : drawer
    int unsigned idx, ep;
    @(negedge clock);
    if (reset && sq_start) begin
      idx = (n_sq - frame_base) & 32'hFF;
      n_sq++;
      ep = epoch;
      rec_addr[idx] = map_addr;
      for (int unsigned k = 1; k <= sq_delay; k++) begin
        @(negedge clock);
        if (ep == epoch) begin
          if (k == 1) begin
            rec_x[idx] = sq_x; rec_y[idx] = sq_y; rec_colour[idx] = sq_colour;
          end else if (sq_x != rec_x[idx] || sq_y != rec_y[idx] || sq_colour != rec_colour[idx]) begin
            hold_viol++;
          end
          if (sq_start) overlap_viol++;
        end
      end
      if (ep == epoch) sq_done = 1'b1;
      @(negedge clock);
      sq_done = 1'b0;
    end
  end

  always @(negedge clock) if (done) n_done++;

  int unsigned n_sq2 = 0, n_done2 = 0;
  logic [7:0]  last_x2, last_addr2;
  logic [6:0]  last_y2;
  logic [17:0] first_colour2;

  always begin : drawer2
    @(negedge clock);
    if (reset && sq_start2) begin
      n_sq2++;
      last_addr2 = map_addr2;
      @(negedge clock);
      last_x2 = sq_x2;
      last_y2 = sq_y2;
      if (n_sq2 == 1) first_colour2 = sq_colour2;
      sq_done2 = 1'b1;
      @(negedge clock);
      sq_done2 = 1'b0;
    end
  end

  always @(negedge clock) if (done2) n_done2++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic kick();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Returns negedges elapsed until done is seen; optionally pokes start in the DONE cycle.
  task automatic wait_done(input int unsigned budget, input bit poke, output int unsigned cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < budget) begin
      @(negedge clock);
      cyc++;
    end
    if (poke) kick();
  endtask

  task automatic wait_squares(input int unsigned n, input int unsigned budget);
    int unsigned c = 0;
    while ((n_sq - frame_base) < n && c < budget) begin
      @(negedge clock);
      c++;
    end
    check("sq_progress", 32'(c < budget), 32'd1);
  endtask

  initial begin : main
    int unsigned cyc, dbase;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_done", 32'(done), 0);
    check("rst_sq_start", 32'(sq_start), 0);
    check("rst_sq_x", 32'(sq_x), 0);
    check("rst_sq_y", 32'(sq_y), 0);
    check("rst_colour", 32'(sq_colour), 0);
    check("rst_addr", 32'(map_addr), 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Frame 1: drawer answers 3 cycles after each request
    sq_delay = 3; frame_base = n_sq; dbase = n_done;
    kick();
    cyc = 0;
    while (!sq_start && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    check("first_sq_latency", cyc + 1, 4);
    wait_done(5000, 1'b0, cyc);
    repeat (10) @(negedge clock);
    check("f1_squares", n_sq - frame_base, 256);
    check("f1_done", n_done - dbase, 1);
    check("f1_first_x", 32'(rec_x[0]), 0);
    check("f1_first_y", 32'(rec_y[0]), 0);
    check("f1_last_x", 32'(rec_x[255]), 60);
    check("f1_last_y", 32'(rec_y[255]), 60);
    check("f1_last_addr", 32'(rec_addr[255]), 255);
    check("col_0_0", 32'(rec_colour[0]), 32'(FLOOR));
    check("col_1_0", 32'(rec_colour[1]), 32'(WALL));
    check("col_2_0", 32'(rec_colour[2]), 32'(DOOR));
    check("col_3_0", 32'(rec_colour[3]), 32'(WALL));
    check("col_0_1", 32'(rec_colour[16]), 32'(WALL));
    check("col_player", 32'(rec_colour[117]), 32'(PLAYER));
    check("addr_5_7", 32'(rec_addr[117]), 117);

    // Frame 2: slow drawer, start during WAIT_SQ and in DONE, player moved mid-frame
    sq_delay = 60; frame_base = n_sq; dbase = n_done;
    kick();
    wait_squares(10, 2000);
    repeat (5) @(negedge clock);
    player_x = 4'd2; player_y = 4'd2;
    kick();
    wait_done(20000, 1'b1, cyc);
    repeat (30) @(negedge clock);
    check("f2_squares", n_sq - frame_base, 256);
    check("f2_done", n_done - dbase, 1);
    check("f2_hold", hold_viol, 0);
    check("f2_overlap", overlap_viol, 0);
    check("f2_player_latched", 32'(rec_colour[117]), 32'(PLAYER));
    check("f2_moved_tile", 32'(rec_colour[34]), 32'(FLOOR));

    // Frame 3: immediate sq_done, full frame length LOAD..DONE inclusive
    player_x = 4'd5; player_y = 4'd7;
    sq_delay = 1; frame_base = n_sq; dbase = n_done;
    kick();
    wait_done(5000, 1'b0, cyc);
    check("f3_frame_len", cyc + 1, 1282);
    repeat (5) @(negedge clock);
    check("f3_squares", n_sq - frame_base, 256);
    check("f3_done", n_done - dbase, 1);

    // Frame 4: reset pulse during tile 40, then a clean redraw
    sq_delay = 3; frame_base = n_sq; dbase = n_done;
    kick();
    wait_squares(41, 2000);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_sq_x", 32'(sq_x), 0);
    check("abort_sq_y", 32'(sq_y), 0);
    check("abort_colour", 32'(sq_colour), 0);
    check("abort_addr", 32'(map_addr), 0);
    check("abort_sq_start", 32'(sq_start), 0);
    check("abort_done", 32'(done), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    check("abort_no_done", n_done - dbase, 0);
    frame_base = n_sq; dbase = n_done;
    kick();
    wait_squares(1, 100);
    repeat (2) @(negedge clock);
    check("restart_x", 32'(rec_x[0]), 0);
    check("restart_y", 32'(rec_y[0]), 0);
    check("restart_addr", 32'(rec_addr[0]), 0);
    wait_done(5000, 1'b0, cyc);
    repeat (5) @(negedge clock);
    check("f4_squares", n_sq - frame_base, 256);
    check("f4_done", n_done - dbase, 1);

    // Offset 8x4 instance
    start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    cyc = 0;
    while (done2 !== 1'b1 && cyc < 2000) begin
      @(negedge clock);
      cyc++;
    end
    check("m2_frame_len", cyc + 1, 162);
    repeat (5) @(negedge clock);
    check("m2_squares", n_sq2, 32);
    check("m2_done", n_done2, 1);
    check("m2_last_x", 32'(last_x2), 60);
    check("m2_last_y", 32'(last_y2), 32);
    check("m2_last_addr", 32'(last_addr2), 31);
    check("m2_player", 32'(first_colour2), 32'(PLAYER));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
